// File: rtl/bcd_addsub_seq_if.sv
// bcd_addsub_seq_if: operand, control, status and display signals of the sequential BCD add/sub unit
interface bcd_addsub_seq_if #(parameter int DIGITS = 2);
    logic [4*DIGITS-1:0] op_a, op_b, result;
    logic sub, carry, neg, err, busy, done;
    logic [7*(DIGITS+1)-1:0] hex_out;
    modport master(output op_a, op_b, sub, input result, carry, neg, err, busy, done, hex_out);
    modport slave(input op_a, op_b, sub, output result, carry, neg, err, busy, done, hex_out);
endinterface

// File: rtl/bcd_addsub_seq.sv
// bcd_addsub_seq: digit-serial BCD adder/subtractor driving DIGITS+1 seven-segment displays
// BCD_SUB_EN enables subtraction and the ten's-complement FIX pass
module bcd_addsub_seq #(parameter int DIGITS = 2) (
    input logic CLOCK_50,
    input logic [3:0] KEY,
    bcd_addsub_seq_if.slave bus
);
    localparam int W = 4*DIGITS;
    localparam int HW = 7*(DIGITS+1);
`ifdef BCD_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif
    typedef enum logic [2:0] {IDLE, LOAD, ADD, FIX, DONE} state_t;
    state_t state, state_nx;
    logic rst_n, start_evt, bad, cout, unused_keys;
    logic [2:0] sync;
    logic [W-1:0] a_r, a_nx, b_r, b_nx, res_r, res_nx;
    logic sub_r, sub_nx, c_r, c_nx, carry_r, carry_nx, neg_r, neg_nx, err_r, err_nx;
    logic busy_r, busy_nx, done_r, done_nx;
    logic [3:0] idx, idx_nx, op_d, bi, dig;
    logic [4:0] s;
    logic [HW-1:0] hex_r;
    assign rst_n = KEY[0];
    assign unused_keys = ^KEY[3:2];
    assign start_evt = sync[2] & ~sync[1];
    function automatic logic [6:0] seg(input logic [3:0] d);
        case (d)
            4'd0: seg = 7'b1000000;
            4'd1: seg = 7'b1111001;
            4'd2: seg = 7'b0100100;
            4'd3: seg = 7'b0110000;
            4'd4: seg = 7'b0011001;
            4'd5: seg = 7'b0010010;
            4'd6: seg = 7'b0000010;
            4'd7: seg = 7'b1111000;
            4'd8: seg = 7'b0000000;
            4'd9: seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
    endfunction
    function automatic logic [HW-1:0] hex_f(input logic [W-1:0] r, input logic c, input logic n, input logic e);
        hex_f = '0;
        for (int k = 0; k < DIGITS; k++) hex_f[7*k+:7] = e ? 7'b1111111 : seg(r[4*k+:4]);
        hex_f[7*DIGITS+:7] = e ? 7'b0000110 : n ? 7'b0111111 : c ? 7'b1111001 : 7'b1111111;
    endfunction
    // one shared digit adder: ADD uses a+b (or a+9-b), FIX uses (9-r)+0
    always_comb begin
        bad = 1'b0;
        for (int k = 0; k < DIGITS; k++) bad |= (bus.op_a[4*k+:4] > 4'd9) || (bus.op_b[4*k+:4] > 4'd9);
        op_d = (state == FIX) ? 4'd9 - res_r[3:0] : a_r[3:0];
        bi = (state == FIX) ? 4'd0 : sub_r ? 4'd9 - b_r[3:0] : b_r[3:0];
        s = {1'b0, op_d} + {1'b0, bi} + {4'd0, c_r};
        cout = s > 5'd9;
        dig = cout ? 4'(s - 5'd10) : s[3:0];
    end
    always_comb begin
        state_nx = state;
        a_nx = a_r;
        b_nx = b_r;
        res_nx = res_r;
        sub_nx = sub_r;
        c_nx = c_r;
        idx_nx = idx;
        carry_nx = carry_r;
        neg_nx = neg_r;
        err_nx = err_r;
        busy_nx = busy_r;
        done_nx = done_r;
        if ((state == IDLE || state == DONE) && start_evt) begin
            state_nx = LOAD;
            busy_nx = 1'b1;
            done_nx = 1'b0;
            carry_nx = 1'b0;
            neg_nx = 1'b0;
            err_nx = 1'b0;
        end else if (state == LOAD) begin
            a_nx = bus.op_a;
            b_nx = bus.op_b;
            sub_nx = SUB_EN && bus.sub;
            c_nx = sub_nx;
            idx_nx = 4'd0;
            state_nx = bad ? DONE : ADD;
            res_nx = bad ? '0 : res_r;
            err_nx = bad;
            busy_nx = !bad;
            done_nx = bad;
        end else if (state == ADD) begin
            a_nx = a_r >> 4;
            b_nx = b_r >> 4;
            res_nx = (res_r >> 4) | (W'(dig) << (W-4));
            c_nx = cout;
            idx_nx = idx + 4'd1;
            if (idx == 4'(DIGITS-1)) begin
                idx_nx = 4'd0;
                c_nx = 1'b1;
                carry_nx = !sub_r && cout;
`ifdef BCD_SUB_EN
                neg_nx = sub_r && !cout;
                state_nx = neg_nx ? FIX : DONE;
`else
                state_nx = DONE;
`endif
                done_nx = state_nx == DONE;
                busy_nx = state_nx != DONE;
            end
`ifdef BCD_SUB_EN
        end else if (state == FIX) begin
            res_nx = (res_r >> 4) | (W'(dig) << (W-4));
            c_nx = cout;
            idx_nx = idx + 4'd1;
            if (idx == 4'(DIGITS-1)) begin
                state_nx = DONE;
                busy_nx = 1'b0;
                done_nx = 1'b1;
            end
`endif
        end
    end
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '1;
            state <= IDLE;
            a_r <= '0;
            b_r <= '0;
            res_r <= '0;
            sub_r <= 1'b0;
            c_r <= 1'b0;
            idx <= 4'd0;
            carry_r <= 1'b0;
            neg_r <= 1'b0;
            err_r <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            hex_r <= hex_f('0, 1'b0, 1'b0, 1'b0);
        end else begin
            sync <= {sync[1:0], KEY[1]};
            state <= state_nx;
            a_r <= a_nx;
            b_r <= b_nx;
            res_r <= res_nx;
            sub_r <= sub_nx;
            c_r <= c_nx;
            idx <= idx_nx;
            carry_r <= carry_nx;
            neg_r <= neg_nx;
            err_r <= err_nx;
            busy_r <= busy_nx;
            done_r <= done_nx;
            hex_r <= hex_f(res_nx, carry_nx, neg_nx, err_nx);
        end
    end
    assign bus.result = res_r;
    assign bus.carry = carry_r;
    assign bus.neg = neg_r;
    assign bus.err = err_r;
    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.hex_out = hex_r;
endmodule

// File: tb/tb_bcd_addsub_seq.sv
// tb_bcd_addsub_seq: directed scoreboard bench for bcd_addsub_seq with DIGITS=2 and DIGITS=4 instances
module tb_bcd_addsub_seq;
`ifdef BCD_SUB_EN
    localparam bit SUB = 1'b1;
`else
    localparam bit SUB = 1'b0;
`endif
    logic clk = 1'b0;
    always #10 clk = ~clk;
    logic [3:0] key2 = 4'hf, key4 = 4'hf;
    bcd_addsub_seq_if #(.DIGITS(2)) bus2();
    bcd_addsub_seq_if #(.DIGITS(4)) bus4();
    bcd_addsub_seq #(.DIGITS(2)) dut2(.CLOCK_50(clk), .KEY(key2), .bus(bus2));
    bcd_addsub_seq #(.DIGITS(4)) dut4(.CLOCK_50(clk), .KEY(key4), .bus(bus4));
    typedef struct {
        logic [31:0] res;
        logic c, n, e;
        int lat;
        logic [62:0] hex;
    } exp_t;
    exp_t sb[$];
    int checks = 0, failures = 0, sel = 2;
    logic [31:0] o_res;
    logic [62:0] o_hex;
    logic o_c, o_n, o_e, o_b, o_d;
    always_comb begin
        o_res = (sel == 4) ? 32'(bus4.result) : 32'(bus2.result);
        o_hex = (sel == 4) ? 63'(bus4.hex_out) : 63'(bus2.hex_out);
        o_c = (sel == 4) ? bus4.carry : bus2.carry;
        o_n = (sel == 4) ? bus4.neg : bus2.neg;
        o_e = (sel == 4) ? bus4.err : bus2.err;
        o_b = (sel == 4) ? bus4.busy : bus2.busy;
        o_d = (sel == 4) ? bus4.done : bus2.done;
    end
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        assert (got === want) else begin
            failures++;
            $error("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask
    function automatic int bcd2i(input logic [31:0] v, input int d);
        int r = 0;
        for (int k = d-1; k >= 0; k--) r = r*10 + int'(v[4*k+:4]);
        return r;
    endfunction
    function automatic logic [31:0] i2bcd(input int x, input int d);
        logic [31:0] r = '0;
        for (int k = 0; k < d; k++) begin
            r[4*k+:4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction
    // glyph codes: 0..9 digits, 10 '-', 11 blank, 12 'E'; bit 0 of the result is segment a
    function automatic logic [0:6] glyph(input int g);
        case (g)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            9: return 7'b0000100;
            10: return 7'b1111110;
            12: return 7'b0110000;
            default: return 7'b1111111;
        endcase
    endfunction
    function automatic logic [62:0] hexm(input logic [31:0] r, input logic c, input logic n, input logic e, input int d);
        logic [62:0] h = '0;
        logic [0:6] g;
        for (int k = 0; k < d; k++) begin
            g = e ? glyph(11) : glyph(int'(r[4*k+:4]));
            for (int j = 0; j < 7; j++) h[7*k+j] = g[j];
        end
        g = e ? glyph(12) : n ? glyph(10) : c ? glyph(1) : glyph(11);
        for (int j = 0; j < 7; j++) h[7*d+j] = g[j];
        return h;
    endfunction
    task automatic expect_op(input int d, input logic [31:0] a, input logic [31:0] b, input bit s);
        exp_t x;
        int m, v;
        bit bad = 1'b0;
        for (int k = 0; k < d; k++) if (a[4*k+:4] > 4'd9 || b[4*k+:4] > 4'd9) bad = 1'b1;
        m = 10**d;
        x.c = 1'b0;
        x.n = 1'b0;
        x.e = bad;
        if (bad) begin
            x.res = '0;
            x.lat = 4;
        end else if (s && SUB) begin
            v = bcd2i(a, d) - bcd2i(b, d);
            x.n = v < 0;
            x.res = i2bcd(v < 0 ? -v : v, d);
            x.lat = (v < 0) ? 4 + 2*d : 4 + d;
        end else begin
            v = bcd2i(a, d) + bcd2i(b, d);
            x.c = v >= m;
            x.res = i2bcd(v % m, d);
            x.lat = 4 + d;
        end
        x.hex = hexm(x.res, x.c, x.n, x.e, d);
        sb.push_back(x);
    endtask
    task automatic set_ops(input int d, input logic [31:0] a, input logic [31:0] b, input bit s);
        if (d == 4) begin
            bus4.op_a = a[15:0];
            bus4.op_b = b[15:0];
            bus4.sub = s;
        end else begin
            bus2.op_a = a[7:0];
            bus2.op_b = b[7:0];
            bus2.sub = s;
        end
    endtask
    task automatic btn(input int d, input logic v);
        if (d == 4) key4[1] = v;
        else key2[1] = v;
    endtask
    // press start, count rising edges until done, then compare against the scoreboard head
    task automatic run(input int d, input logic [31:0] a, input logic [31:0] b, input bit s, input bit repress);
        exp_t x;
        int cnt = 0;
        bit seen = 1'b0;
        @(negedge clk);
        sel = d;
        set_ops(d, a, b, s);
        expect_op(d, a, b, s);
        btn(d, 1'b0);
        while (!seen && cnt < 40) begin
            @(negedge clk);
            cnt++;
            if (cnt == 1) btn(d, 1'b1);
            if (cnt == 3) begin
                chk("busy_load", o_b, 1'b1);
                chk("done_clr", o_d, 1'b0);
                if (repress) btn(d, 1'b0);
            end
            if (cnt == 4) begin
                if (repress) btn(d, 1'b1);
                set_ops(d, 32'h0, 32'hffff_ffff, ~s);
            end
            if (cnt >= 3 && o_d) seen = 1'b1;
        end
        x = sb.pop_front();
        chk("latency", 64'(cnt), 64'(x.lat));
        chk("result", o_res, x.res);
        chk("carry", o_c, x.c);
        chk("neg", o_n, x.n);
        chk("err", o_e, x.e);
        chk("busy_done", o_b, 1'b0);
        chk("hex", o_hex, x.hex);
        repeat (6) @(negedge clk);
        chk("hold_done", o_d, 1'b1);
        chk("hold_result", o_res, x.res);
    endtask
    initial begin
        bus2.op_a = '0;
        bus2.op_b = '0;
        bus2.sub = 1'b0;
        bus4.op_a = '0;
        bus4.op_b = '0;
        bus4.sub = 1'b0;
        key2[0] = 1'b0;
        key4[0] = 1'b0;
        #1;
        chk("rst_result2", bus2.result, 8'h00);
        chk("rst_flags2", {bus2.carry, bus2.neg, bus2.err, bus2.busy, bus2.done}, 5'b0);
        chk("rst_hex2", bus2.hex_out, hexm(0, 0, 0, 0, 2));
        chk("rst_hex4", bus4.hex_out, hexm(0, 0, 0, 0, 4));
        repeat (3) @(negedge clk);
        key2[0] = 1'b1;
        key4[0] = 1'b1;
        repeat (2) @(negedge clk);
        run(2, 32'h45, 32'h67, 1'b0, 1'b0);
        run(2, 32'h99, 32'h99, 1'b0, 1'b0);
        run(2, 32'h67, 32'h45, 1'b1, 1'b0);
        run(2, 32'h45, 32'h67, 1'b1, 1'b0);
        run(2, 32'h4A, 32'h01, 1'b0, 1'b0);
        run(2, 32'h38, 32'h38, 1'b1, 1'b0);
        run(2, 32'h03, 32'h90, 1'b1, 1'b0);
        run(4, 32'h9999, 32'h0001, 1'b0, 1'b1);
        run(4, 32'h1234, 32'h5678, 1'b1, 1'b0);
        // reset asserted in the middle of an add aborts it
        @(negedge clk);
        sel = 2;
        set_ops(2, 32'h45, 32'h67, 1'b0);
        btn(2, 1'b0);
        @(negedge clk);
        btn(2, 1'b1);
        repeat (4) @(negedge clk);
        chk("busy_pre_rst", o_b, 1'b1);
        key2[0] = 1'b0;
        #1;
        chk("arst_result", o_res, 32'h0);
        chk("arst_flags", {o_c, o_n, o_e, o_b, o_d}, 5'b0);
        chk("arst_hex", o_hex, hexm(0, 0, 0, 0, 2));
        repeat (2) @(negedge clk);
        key2[0] = 1'b1;
        repeat (2) @(negedge clk);
        run(2, 32'h45, 32'h67, 1'b0, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bcd_addsub_seq.md
# bcd_addsub_seq

Parametrised, clocked successor to the board's two-digit BCD adder. Accepts two DIGITS-wide packed-BCD operands, validates them, and computes the sum or signed difference digit-serially, least-significant digit first, one digit per clock. It drives DIGITS+1 active-low seven-segment displays: the DIGITS result digits plus one carry/sign position. It sits between the switch/button inputs and the HEX displays of the DE2-class board top level.

## Interface
- DIGITS, default 2: number of BCD digits per operand, legal range 1..8.
- CLOCK_50  in  1  board clock, all state on rising edge.
- KEY  in  4  active-low buttons.
  - KEY[0]: asynchronous active-low reset.
  - KEY[1]: start, raw and unsynchronised.
  - KEY[3:2]: unused.
- op_a  in  4*DIGITS  packed BCD operand A; the least-significant digit is in bits [3:0].
- op_b  in  4*DIGITS  packed BCD operand B, same packing as op_a.
- sub  in  1  0 = A+B, 1 = A−B; sampled in LOAD.
- result  out  4*DIGITS  packed BCD magnitude of the result.
- carry  out  1  decimal carry out of the addition.
- neg  out  1  subtraction result is negative; result holds the magnitude.
- err  out  1  an operand contained a nibble greater than 9.
- busy  out  1  high in LOAD, ADD and FIX.
- done  out  1  result valid; held until the next accepted start.
- hex_out  out  7*(DIGITS+1)  segment patterns, [0:6] = segments a..g, active-low.
  - Display k for k < DIGITS shows result digit k.
  - Display DIGITS is the MS position.

## Operation
- Start detection: KEY[1] passes through a 2-FF synchroniser and a falling-edge detector, producing a 1-cycle start_evt.
  - start_evt is honoured only in IDLE or DONE; otherwise it is ignored.
- States: IDLE → LOAD → ADD → (FIX) → DONE; DONE → LOAD on start_evt.
- LOAD (1 cycle):
  - Capture op_a, op_b and sub; clear done, carry, neg and err; set busy.
  - If any nibble of either operand is >9, go to DONE with err=1 and result=0.
  - Otherwise go to ADD.
- ADD (DIGITS cycles): digit index i runs 0..DIGITS−1.
  - Add: s = a_i + b_i + c_in; if s>9 then digit = s−10 (i.e. s+6 mod 16) and c_out=1.
  - Sub: b_i is replaced by 9−b_i, and c_in of digit 0 is 1 (ten's complement).
  - After the last digit:
    - Add: carry = final c_out.
    - Sub with final c_out=1: positive, discard c_out, go to DONE.
    - Sub with final c_out=0: negative, set neg=1, go to FIX.
- FIX (DIGITS cycles, only if BCD_SUB_EN): in-place ten's complement of result (9−r_i, +1 at digit 0, BCD carry). Then go to DONE.
- Operand or sub changes after LOAD have no effect on the operation in progress.
- Encodings:
  - Digits 0–9: 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111, 0000000, 0000100.
  - '-' = 1111110, blank = 1111111, 'E' = 0110000.
- MS display:
  - 'E' if err.
  - Else '-' if neg.
  - Else '1' if carry.
  - Else blank.
- When err=1, all result displays are blank.

## Timing
- Reset (KEY[0] low, asynchronous): state=IDLE; result=0, carry=0, neg=0, err=0, busy=0, done=0.
  - Result displays show '0'; MS display is blank; synchroniser flops are cleared to 1 (button released).
- Reset asserted mid-operation aborts immediately. No partial result is retained.
- Let cycle N be the cycle in which start_evt is high, in IDLE or DONE:
  - LOAD occurs at N+1.
  - ADD occupies N+2..N+1+DIGITS.
  - done=1 from N+2+DIGITS when no FIX is needed.
  - With FIX, done=1 from N+2+2·DIGITS.
  - On err, done=1 at N+2.
- Button press to start_evt: 3 cycles (2 synchroniser stages + edge detect).
- result, carry, neg and hex_out are registered. They change only during ADD/FIX or on reset, and are stable whenever done=1.
- The zero difference (A−A) gives result=0, neg=0.

## Configuration
- BCD_SUB_EN defined: the sub input and the FIX state are implemented as described above.
- BCD_SUB_EN undefined:
  - sub is ignored and treated as 0; FIX is not synthesised.
  - neg is tied to 0 and the '-' glyph is never shown.
  - Add latency is unchanged.

## Test plan
- DIGITS=2, A=0x45, B=0x67, sub=0, KEY[1] pulse → result=0x12, carry=1, neg=0; done at N+4; MS display '1'.
- DIGITS=2, A=0x99, B=0x99, sub=0 → result=0x98, carry=1.
- DIGITS=2, sub=1 (BCD_SUB_EN):
  - A=0x67, B=0x45 → result=0x22, neg=0, done at N+4.
  - A=0x45, B=0x67 → result=0x22, neg=1, done at N+6, MS display '-'.
- DIGITS=2, A=0x4A, B=0x01 → err=1, result=0, done at N+2, MS display 'E', other displays blank.
- DIGITS=4, A=0x9999, B=0x0001, sub=0 → result=0x0000, carry=1.
  - Second start_evt issued during ADD is ignored, and done timing is unchanged.
- KEY[0] asserted at N+3 of an add → all outputs return to reset values asynchronously.
  - After release, a new start computes correctly.
